ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the team's ram_rtl block.
- Accepts read/write commands from requesters A and B on a valid/grant handshake.
- Issues at most one RAM command per cycle on registered RAM strobes.
- Routes each returned read word back to the requester that issued it; commands are accepted and returned in order.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- RD_LATENCY, 1, cycles from the RAM sampling rd_enable to data_out being valid (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset: asynchronous, active-low.
- a_req  in  1  A command valid.
- a_we  in  1  A command is write (1) or read (0).
- a_addr  in  ADDR_WIDTH  A address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_gnt  out  1  A command accepted this cycle.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_WIDTH  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for B.
- ram_rd_enable  out  1  to RAM rd_enable.
- ram_wr_enable  out  1  to RAM wr_enable.
- ram_rd_address  out  ADDR_WIDTH  to RAM rd_address.
- ram_wr_address  out  ADDR_WIDTH  to RAM wr_address.
- ram_data_in  out  DATA_WIDTH  to RAM data_in.
- ram_data_out  in  DATA_WIDTH  from RAM data_out.

Behaviour:
- Reset (rst low, async):
  - all outputs 0.
  - priority pointer = A.
  - read-tag pipeline cleared.
  - no rvalid may be produced for commands accepted before reset.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - gnt is combinational from req and the pointer.
  - A command transfers in a cycle where req & gnt.
- Arbitration:
  - Only one req high: it is granted.
  - Both high: grant the pointer side; the pointer then flips to the other side.
  - Pointer updates only on a grant.
  - a_gnt and b_gnt are never both 1.
- Command issue: a command accepted in cycle N drives the RAM in cycle N+1 from registers.
  - Write: ram_wr_enable=1, ram_wr_address=addr, ram_data_in=wdata.
  - Read: ram_rd_enable=1, ram_rd_address=addr.
  - Strobes last exactly one cycle; ram_rd_enable and ram_wr_enable are never both 1.
  - Address and data outputs hold their last values when idle.
- Read return: a read issued to the RAM in cycle M returns in cycle M+RD_LATENCY.
  - The matching x_rvalid=1 for that one cycle.
  - x_rdata = ram_data_out (combinational passthrough); the other side's rdata = 0.
  - Tag pipeline: RD_LATENCY stages of {valid, owner}, shifted every cycle.
- Throughput: one command per cycle sustained. A read at cycle N has rvalid at N+1+RD_LATENCY.
- Ordering:
  - Write then read to the same address in consecutive grants: the read returns the new data.
  - The RAM is expected to be write-then-read ordered across cycles; same-cycle hazards cannot occur.
- Writes produce no response.
- Reset asserted mid-operation: in-flight reads are discarded (no rvalid) and strobes drop immediately.

Decomposition:
- Package ram_arb_pkg:
  - typedef owner_t (enum OWN_A, OWN_B).
  - struct ram_cmd_t {we, addr, wdata}.
  - struct rd_tag_t {valid, owner_t owner}.
  - Default width constants.
- One sub-module: ram_arb_rr (2-way round-robin grant plus pointer register).
- Command register and tag pipeline stay in the top.

Test Plan:
- Reset release, A writes addr 3 = 8'hA5, then A reads addr 3 -> ram_wr_enable pulse one cycle with address 3; a_rvalid=1 with a_rdata=8'hA5 two cycles after the read grant (RD_LATENCY=1); b_rvalid stays 0.
- A and B both request continuously (reads of addrs 1 and 2) for 4 cycles -> grants A,B,A,B; ram_rd_address 1,2,1,2; rvalids alternate a,b,a,b with the correct data.
- Only B requests after a prior A grant -> b_gnt immediately; when both then request, A is granted next (pointer was B-consumed).
- B writes addr 7 = 8'h3C, A reads addr 7 in the next cycle -> a_rdata=8'h3C.
- rst pulled low the cycle after an A read is granted -> all outputs 0 asynchronously, no a_rvalid afterwards; after release the first dual request grants A.
- RD_LATENCY=3 build, back-to-back reads A(addr0), B(addr1), A(addr2) -> rvalids appear 4, 5 and 6 cycles after the first grant, each on the correct owner.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RD_LATENCY = 1;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } ram_cmd_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  function automatic owner_t other_side(input owner_t o);
    return (o == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin grant with a priority pointer that moves only on a grant.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  owner_t ptr_q, ptr_d;

  // Grants are gated by reset so every output reads 0 while rst_n is low.
  always_comb begin
    a_gnt_o = rst_n & a_req_i & (~b_req_i | (ptr_q == OWN_A));
    b_gnt_o = rst_n & b_req_i & (~a_req_i | (ptr_q == OWN_B));
    ptr_d   = ptr_q;
    if (a_gnt_o)      ptr_d = other_side(OWN_A);
    else if (b_gnt_o) ptr_d = other_side(OWN_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= OWN_A;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer in front of ram_rtl: registers one command per cycle
// onto the RAM strobes and steers each read word back to its issuer.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_rd_enable,
  output logic                  ram_wr_enable,
  output logic [ADDR_WIDTH-1:0] ram_rd_address,
  output logic [ADDR_WIDTH-1:0] ram_wr_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  owner_t                owner_q, owner_d;
  rd_tag_t               tag_q [RD_LATENCY];

  logic                  accept;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  ram_arb_rr u_rr (
    .clk     (clk),
    .rst_n   (rst),
    .a_req_i (a_req),
    .b_req_i (b_req),
    .a_gnt_o (a_gnt),
    .b_gnt_o (b_gnt)
  );

  always_comb begin
    accept    = a_gnt | b_gnt;
    cmd_we    = a_gnt ? a_we    : b_we;
    cmd_addr  = a_gnt ? a_addr  : b_addr;
    cmd_wdata = a_gnt ? a_wdata : b_wdata;
    rd_en_d   = accept & ~cmd_we;
    wr_en_d   = accept &  cmd_we;
    rd_addr_d = rd_en_d ? cmd_addr  : rd_addr_q;
    wr_addr_d = wr_en_d ? cmd_addr  : wr_addr_q;
    data_d    = wr_en_d ? cmd_wdata : data_q;
    owner_d   = owner_q;
    if (rd_en_d) owner_d = a_gnt ? OWN_A : OWN_B;
  end

  // Tag stage 0 is loaded from the strobe actually presented to the RAM, so the
  // last stage lines up with ram_data_out RD_LATENCY cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      data_q    <= '0;
      owner_q   <= OWN_A;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '{valid: 1'b0, owner: OWN_A};
    end else begin
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      data_q    <= data_d;
      owner_q   <= owner_d;
      tag_q[0]  <= '{valid: rd_en_q, owner: owner_q};
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    ram_rd_enable  = rd_en_q;
    ram_wr_enable  = wr_en_q;
    ram_rd_address = rd_addr_q;
    ram_wr_address = wr_addr_q;
    ram_data_in    = data_q;
    a_rvalid       = tag_q[RD_LATENCY-1].valid & (tag_q[RD_LATENCY-1].owner == OWN_A);
    b_rvalid       = tag_q[RD_LATENCY-1].valid & (tag_q[RD_LATENCY-1].owner == OWN_B);
    a_rdata        = a_rvalid ? ram_data_out : '0;
    b_rdata        = b_rvalid ? ram_data_out : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one DUT at RD_LATENCY=1 and one at 3, each with a small RAM model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT, RD_LATENCY = 1 ----------------
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [3:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       r_rd_en, r_wr_en;
  logic [3:0] r_rd_addr, r_wr_addr;
  logic [7:0] r_din, r_dout;

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_rd_enable(r_rd_en), .ram_wr_enable(r_wr_en),
    .ram_rd_address(r_rd_addr), .ram_wr_address(r_wr_addr),
    .ram_data_in(r_din), .ram_data_out(r_dout)
  );

  logic [7:0] mem1 [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                            8'h18, 8'h19, 8'h1a, 8'h1b, 8'h1c, 8'h1d, 8'h1e, 8'h1f};
  logic [7:0] rd1_q = 8'h00;
  always @(posedge clk) begin
    if (r_wr_en) mem1[r_wr_addr] <= r_din;
    if (r_rd_en) rd1_q <= mem1[r_rd_addr];
  end
  assign r_dout = rd1_q;

  // ---------------- DUT, RD_LATENCY = 3 ----------------
  logic       a3_req = 0, a3_we = 0, b3_req = 0, b3_we = 0;
  logic [3:0] a3_addr = 0, b3_addr = 0;
  logic [7:0] a3_wdata = 0, b3_wdata = 0;
  logic       a3_gnt, a3_rvalid, b3_gnt, b3_rvalid;
  logic [7:0] a3_rdata, b3_rdata;
  logic       r3_rd_en, r3_wr_en;
  logic [3:0] r3_rd_addr, r3_wr_addr;
  logic [7:0] r3_din, r3_dout;

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
    .a_gnt(a3_gnt), .a_rvalid(a3_rvalid), .a_rdata(a3_rdata),
    .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
    .b_gnt(b3_gnt), .b_rvalid(b3_rvalid), .b_rdata(b3_rdata),
    .ram_rd_enable(r3_rd_en), .ram_wr_enable(r3_wr_en),
    .ram_rd_address(r3_rd_addr), .ram_wr_address(r3_wr_addr),
    .ram_data_in(r3_din), .ram_data_out(r3_dout)
  );

  logic [7:0] mem3 [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                            8'h18, 8'h19, 8'h1a, 8'h1b, 8'h1c, 8'h1d, 8'h1e, 8'h1f};
  logic [7:0] s0_q = 0, s1_q = 0, s2_q = 0;
  always @(posedge clk) begin
    if (r3_wr_en) mem3[r3_wr_addr] <= r3_din;
    s0_q <= mem3[r3_rd_addr];
    s1_q <= s0_q;
    s2_q <= s1_q;
  end
  assign r3_dout = s2_q;

  // ---------------- helpers ----------------
  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #4 rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_req = 1; b_req = 1;
    #12;
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, r_rd_en, r_wr_en,
         r_rd_addr, r_wr_addr, r_din} !== '0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b%b rv=%b%b rd_en=%b wr_en=%b expected all 0",
               a_gnt, b_gnt, a_rvalid, b_rvalid, r_rd_en, r_wr_en);
    end
    start_cycle();
    a_req = 0; b_req = 0;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    start_cycle();
    a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'hA5;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL wr_grant a_gnt=%b b_gnt=%b expected 1 0", a_gnt, b_gnt);
    end
    start_cycle();
    a_we = 0; a_addr = 4'd3;
    @(negedge clk);
    checks++;
    if (r_wr_en !== 1'b1 || r_wr_addr !== 4'd3 || r_din !== 8'hA5 || r_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL wr_strobe wr_en=%b addr=%0d din=%h rd_en=%b expected 1 3 a5 0",
               r_wr_en, r_wr_addr, r_din, r_rd_en);
    end
    start_cycle();
    a_req = 0;
    @(negedge clk);
    checks++;
    if (r_wr_en !== 1'b0 || r_rd_en !== 1'b1 || r_rd_addr !== 4'd3 || a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_strobe wr_en=%b rd_en=%b addr=%0d a_rvalid=%b expected 0 1 3 0",
               r_wr_en, r_rd_en, r_rd_addr, a_rvalid);
    end
    start_cycle();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'hA5 || b_rvalid !== 1'b0 || b_rdata !== 8'h00 ||
        r_rd_en !== 1'b0 || r_rd_addr !== 4'd3) begin
      errors++;
      $display("FAIL rd_return a_rv=%b a_rdata=%h b_rv=%b b_rdata=%h rd_en=%b expected 1 a5 0 00 0",
               a_rvalid, a_rdata, b_rvalid, b_rdata, r_rd_en);
    end
    start_cycle();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_single_pulse a_rvalid=%b expected 0", a_rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_a_gnt = 6'b000101;
    logic [5:0] exp_b_gnt = 6'b001010;
    logic [5:0] exp_rd_en = 6'b011110;
    logic [5:0] exp_a_rv  = 6'b010100;
    logic [5:0] exp_b_rv  = 6'b101000;
    logic [3:0] exp_addr [6] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd2};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      start_cycle();
      a_req = (k < 4); a_we = 0; a_addr = 4'd1;
      b_req = (k < 4); b_we = 0; b_addr = 4'd2;
      @(negedge clk);
      checks++;
      if (a_gnt !== exp_a_gnt[k] || b_gnt !== exp_b_gnt[k]) begin
        errors++;
        $display("FAIL rr_grant cycle %0d gnt=%b%b expected %b%b", k, a_gnt, b_gnt,
                 exp_a_gnt[k], exp_b_gnt[k]);
      end
      checks++;
      if (a_rvalid !== exp_a_rv[k] || b_rvalid !== exp_b_rv[k] ||
          a_rdata !== (exp_a_rv[k] ? 8'h11 : 8'h00) || b_rdata !== (exp_b_rv[k] ? 8'h12 : 8'h00)) begin
        errors++;
        $display("FAIL rr_return cycle %0d rv=%b%b a_rdata=%h b_rdata=%h expected rv=%b%b",
                 k, a_rvalid, b_rvalid, a_rdata, b_rdata, exp_a_rv[k], exp_b_rv[k]);
      end
      if (k >= 1) begin
        checks++;
        if (r_rd_en !== exp_rd_en[k] || r_rd_addr !== exp_addr[k] || r_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL rr_strobe cycle %0d rd_en=%b addr=%0d wr_en=%b expected %b %0d 0",
                   k, r_rd_en, r_rd_addr, r_wr_en, exp_rd_en[k], exp_addr[k]);
        end
      end
    end
  endtask

  task automatic test_pointer();
    logic [3:0] exp_a_gnt = 4'b0101;
    logic [3:0] exp_b_gnt = 4'b1010;
    logic [3:0] drv_a     = 4'b0101;
    logic [3:0] drv_b     = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      start_cycle();
      a_req = drv_a[k]; a_we = 0; a_addr = 4'd0;
      b_req = drv_b[k]; b_we = 0; b_addr = 4'd4;
      @(negedge clk);
      checks++;
      if (a_gnt !== exp_a_gnt[k] || b_gnt !== exp_b_gnt[k]) begin
        errors++;
        $display("FAIL ptr_grant cycle %0d gnt=%b%b expected %b%b", k, a_gnt, b_gnt,
                 exp_a_gnt[k], exp_b_gnt[k]);
      end
    end
    start_cycle();
    a_req = 0; b_req = 0;
    repeat (3) start_cycle();
  endtask

  task automatic test_b_write_a_read();
    start_cycle();
    b_req = 1; b_we = 1; b_addr = 4'd7; b_wdata = 8'h3C;
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
      errors++; $display("FAIL bw_grant gnt=%b%b expected 01", a_gnt, b_gnt);
    end
    start_cycle();
    b_req = 0; b_we = 0;
    a_req = 1; a_we = 0; a_addr = 4'd7;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || r_wr_en !== 1'b1 || r_wr_addr !== 4'd7 || r_din !== 8'h3C) begin
      errors++;
      $display("FAIL bw_strobe a_gnt=%b wr_en=%b addr=%0d din=%h expected 1 1 7 3c",
               a_gnt, r_wr_en, r_wr_addr, r_din);
    end
    start_cycle();
    a_req = 0;
    start_cycle();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'h3C || b_rvalid !== 1'b0 || b_rdata !== 8'h00) begin
      errors++;
      $display("FAIL bw_return a_rv=%b a_rdata=%h b_rv=%b b_rdata=%h expected 1 3c 0 00",
               a_rvalid, a_rdata, b_rvalid, b_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int bad_rv = 0;
    start_cycle();
    a_req = 1; a_we = 0; a_addr = 4'd3;
    start_cycle();
    a_req = 0;
    #2;
    checks++;
    if (r_rd_en !== 1'b1) begin
      errors++; $display("FAIL mid_pre_strobe rd_en=%b expected 1", r_rd_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, r_rd_en, r_wr_en,
         r_rd_addr, r_wr_addr, r_din} !== '0) begin
      errors++;
      $display("FAIL mid_async_clear rd_en=%b rd_addr=%0d wr_addr=%0d din=%h expected all 0",
               r_rd_en, r_rd_addr, r_wr_addr, r_din);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) bad_rv++;
      start_cycle();
    end
    checks++;
    if (bad_rv != 0) begin
      errors++; $display("FAIL mid_no_rvalid stale rvalid cycles=%0d expected 0", bad_rv);
    end
    a_req = 1; b_req = 1; a_addr = 4'd0; b_addr = 4'd0;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL mid_ptr_reset gnt=%b%b expected 10", a_gnt, b_gnt);
    end
    start_cycle();
    a_req = 0; b_req = 0;
    repeat (3) start_cycle();
  endtask

  task automatic test_latency3();
    logic [7:0] exp_a_rv = 8'b0101_0000;
    logic [7:0] exp_b_rv = 8'b0010_0000;
    logic [7:0] exp_data [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h00};
    for (int k = 0; k < 8; k++) begin
      start_cycle();
      a3_we = 0; b3_we = 0;
      a3_req = (k < 3); a3_addr = (k == 0) ? 4'd0 : 4'd2;
      b3_req = (k < 2); b3_addr = 4'd1;
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (a3_gnt !== (k != 1) || b3_gnt !== (k == 1)) begin
          errors++; $display("FAIL l3_grant cycle %0d gnt=%b%b", k, a3_gnt, b3_gnt);
        end
      end
      checks++;
      if (a3_rvalid !== exp_a_rv[k] || b3_rvalid !== exp_b_rv[k] ||
          (a3_rvalid ? a3_rdata : b3_rdata) !== exp_data[k]) begin
        errors++;
        $display("FAIL l3_return cycle %0d rv=%b%b a_rdata=%h b_rdata=%h expected rv=%b%b data=%h",
                 k, a3_rvalid, b3_rvalid, a3_rdata, b3_rdata, exp_a_rv[k], exp_b_rv[k], exp_data[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_pointer();
    test_b_write_a_read();
    test_reset_mid();
    test_latency3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
